// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder that reuses one 4-bit ripple slice, one nibble per clock.
// Define NSA_SUBTRACT_EN to add the sub input (a - b via inverted B and carry-in of 1).
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             carry_p0;
  logic [4:0]       slice;
  logic             last;
  logic             sub_i;

`ifdef NSA_SUBTRACT_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // One full-adder chain; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[4], s};
  endfunction

  assign slice = nib_add(a_p0[{idx, 2'b00} +: 4], b_p0[{idx, 2'b00} +: 4], carry_p0);
  assign last  = (idx == IW'(NIB - 1));
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture in IDLE, then one nibble of sum per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0     <= '0;
      b_p0     <= '0;
      carry_p0 <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_p0     <= a;
            b_p0     <= sub_i ? ~b : b;
            carry_p0 <= sub_i ? 1'b1 : cin;
            sum      <= '0;
            idx      <= '0;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= slice[3:0];
          carry_p0               <= slice[4];
          if (last) begin
            cout <= slice[4];
            idx  <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed bench for nibble_serial_add_ctrl (WIDTH=16), with an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int ncmp = 0;
  int nerr = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NSA_SUBTRACT_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic tc, input logic ts,
                       output logic [WIDTH-1:0] es, output logic ec);
    longint unsigned tot;
`ifdef NSA_SUBTRACT_EN
    if (ts) begin
      es = ta - tb_;
      ec = (ta >= tb_);
    end else
`endif
    begin
      tot = longint'(ta) + longint'(tb_) + longint'(tc);
      es  = tot[WIDTH-1:0];
      ec  = tot[WIDTH];
    end
  endtask

  // Full transaction from IDLE; optionally scrambles inputs and start during RUN.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic tc, input logic ts, input bit scramble);
    logic [WIDTH-1:0] es;
    logic             ec;
    model(ta, tb_, tc, ts, es, ec);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    start = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (scramble) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        start = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    @(posedge clk); #1;
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("sum_hold", sum, es);
    chk("cout_hold", cout, ec);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h1234, 16'h1111, 1'b1, 1'b0, 1);

    // Start held high across the whole first transaction.
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 16'h1000; b = 16'h1000;
    repeat (NIB) begin
      @(posedge clk); #1;
    end
    chk("hold_done1", done, 1);
    chk("hold_sum1", sum, 16'h0002);
    @(posedge clk); #1;
    chk("hold_idle", busy, 0);
    @(posedge clk); #1;
    chk("hold_accept", busy, 1);
    start = 1'b0;
    repeat (NIB) begin
      @(posedge clk); #1;
    end
    chk("hold_done2", done, 1);
    chk("hold_sum2", sum, 16'h2000);
    chk("hold_cout2", cout, 0);

    // Leave cout=1 behind, then reset in the 2nd RUN cycle.
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 2; i++) begin
      @(posedge clk); #1;
      chk("arst_nodone", done, 0);
    end
    do_op(16'h1234, 16'h1111, 1'b1, 1'b0, 0);

`ifdef NSA_SUBTRACT_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 8 == 0) rb = ~ra;
      do_op(ra, rb, 1'($urandom), 1'($urandom), (n % 2) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencing controller that reuses a single 4-bit ripple adder slice (full-adder chain, carry in/out) to add WIDTH-bit operands one nibble per clock.
- Latches operands on a start handshake.
- Steps LSB nibble to MSB nibble, carrying through a registered carry.
- Reports the result with a one-cycle done pulse.
- Sits between a requester (test sequencer or ALU front end) and the shared 4-bit adder datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
NIB, WIDTH/4, number of nibble steps (derived, not overridable).

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      asynchronous active-low reset
start   input   1      request; sampled only in IDLE
a       input   WIDTH  operand A; sampled on accepted start
b       input   WIDTH  operand B; sampled on accepted start
cin     input   1      carry-in; sampled on accepted start
busy    output  1      high in RUN and DONE
done    output  1      one-cycle pulse; result valid
sum     output  WIDTH  result register
cout    output  1      final carry out of MSB nibble

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, idx=0, carry=0, operand regs=0.
  - sum=0, cout=0, busy=0, done=0.
  - Deassertion takes effect at the next clk edge.
- States: IDLE, RUN, DONE. Encoding is free; outputs are registered or decoded from state only, never from inputs.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch a->A_r, b->B_r, cin->carry; clear sum to 0; idx=0; go to RUN.
  - start=0: stay in IDLE; sum and cout hold their values.
- RUN (busy=1):
  - Each edge: slice inputs are A_r[4*idx+:4], B_r[4*idx+:4], carry.
  - sum[4*idx+:4] <= slice sum; carry <= slice carry-out; idx <= idx+1.
  - When idx==NIB-1: also cout <= slice carry-out, idx <= 0, go to DONE.
- DONE: busy=1, done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NIB, i.e. NIB cycles after acceptance. The next start can be accepted at edge k+NIB+2 at the earliest.
- start while busy=1 (RUN or DONE): ignored; no queuing; operands not resampled.
- a, b and cin may change freely after acceptance without affecting the result.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- Partial sum bits are visible during RUN. Consumers must only use sum/cout while done=1 or in IDLE after done.
- WIDTH=4: single RUN cycle; behaves identically with NIB=1.

Optional Feature:
Macro NSA_SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on an accepted start.
  - sub=1: B_r is latched as ~b and carry is initialised to 1 (cin ignored), so sum = a - b mod 2^WIDTH. cout=1 means no borrow; cout=0 means borrow.
  - sub=0: behaves exactly as the base block.
- Undefined: no sub port; addition only. Timing is identical in both builds.

Test Plan (WIDTH=16):
- a=0x00FF, b=0x0001, cin=0, start pulse -> busy high for 5 cycles; done pulses 4 cycles after accept; sum=0x0100, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
- a=0x1234, b=0x1111, cin=1 -> sum=0x2346, cout=0. Then change a/b mid-RUN -> result unchanged.
- Accept a=0x0001, b=0x0001. Hold start=1 continuously with new operands 0x1000+0x1000 -> first done gives 0x0002. The second request is accepted only after return to IDLE and gives 0x2000.
- rst_n low during 2nd RUN cycle -> busy, done, sum and cout go 0 immediately. No done pulse follows. The next start gives a correct result.
- NSA_SUBTRACT_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
